// File: rtl/bonus_box_scorer.sv
// bonus_box_scorer: per-level scoring for the maze game.
// Watches player moves for the +BONUS / -BONUS boxes, keeps a saturating score,
// applies a one-point time penalty per scoreTick and hands each collected box
// to the drawer as a single erase request held until it is acknowledged.
module bonus_box_scorer #(
  parameter int SCORE_W     = 8,
  parameter int START_SCORE = 50,
  parameter int MAX_SCORE   = 99,
  parameter int BONUS       = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               playHard,
  input  logic               playMedium,
  input  logic               playEasy,
  input  logic               externalReset,
  input  logic [4:0]         scorePlusFiveX,
  input  logic [4:0]         scorePlusFiveY,
  input  logic [4:0]         scoreMinusFiveX,
  input  logic [4:0]         scoreMinusFiveY,
  input  logic [4:0]         playerX,
  input  logic [4:0]         playerY,
  input  logic               moveValid,
  input  logic               scoreTick,
  input  logic               levelDone,
  input  logic               eraseAck,
  output logic [SCORE_W-1:0] score,
  output logic               plusBoxActive,
  output logic               minusBoxActive,
  output logic               eraseReq,
  output logic [4:0]         eraseX,
  output logic [4:0]         eraseY,
  output logic               levelActive,
  output logic               gameOver
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    ERASE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] START_S = SCORE_W'(START_SCORE);
  localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] BONUS_S = SCORE_W'(BONUS);
  // One extra bit so the +BONUS sum cannot wrap before it is clamped.
  localparam logic [SCORE_W:0]   MAX_X   = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [SCORE_W:0]   BONUS_X = (SCORE_W+1)'(BONUS);

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic               plus_active_reg, plus_active_next;
  logic               minus_active_reg, minus_active_next;
  logic               erase_req_reg, erase_req_next;
  logic [4:0]         erase_x_reg, erase_x_next;
  logic [4:0]         erase_y_reg, erase_y_next;
  logic               done_pending_reg, done_pending_next;
  logic               level_active_reg, game_over_reg;

  logic               one_sel;
  logic               plus_hit;
  logic               minus_hit;
  logic [SCORE_W:0]   plus_sum;
  logic [SCORE_W-1:0] plus_score;
  logic [SCORE_W-1:0] minus_score;
  logic [SCORE_W-1:0] bonus_score;

  // Saturating decrement used for the time penalty.
  function automatic logic [SCORE_W-1:0] dec_sat(input logic [SCORE_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // A level starts only when exactly one difficulty is selected.
  always_comb begin
    one_sel = 1'b0;
    case ({playHard, playMedium, playEasy})
      3'b001, 3'b010, 3'b100: one_sel = 1'b1;
      default:                one_sel = 1'b0;
    endcase
  end

  assign plus_hit  = plus_active_reg &&
                     (playerX == scorePlusFiveX) && (playerY == scorePlusFiveY);
  assign minus_hit = minus_active_reg &&
                     (playerX == scoreMinusFiveX) && (playerY == scoreMinusFiveY);

  assign plus_sum    = {1'b0, score_reg} + BONUS_X;
  assign plus_score  = (plus_sum > MAX_X) ? MAX_S : plus_sum[SCORE_W-1:0];
  assign minus_score = (score_reg >= BONUS_S) ? (score_reg - BONUS_S) : '0;

  // Next-state and next-output logic for the level FSM.
  always_comb begin
    state_next        = state_reg;
    score_next        = score_reg;
    plus_active_next  = plus_active_reg;
    minus_active_next = minus_active_reg;
    erase_req_next    = erase_req_reg;
    erase_x_next      = erase_x_reg;
    erase_y_next      = erase_y_reg;
    done_pending_next = done_pending_reg;
    bonus_score       = score_reg;

    if (externalReset) begin
      state_next        = IDLE;
      score_next        = START_S;
      plus_active_next  = 1'b1;
      minus_active_next = 1'b1;
      erase_req_next    = 1'b0;
      erase_x_next      = '0;
      erase_y_next      = '0;
      done_pending_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          score_next        = START_S;
          plus_active_next  = 1'b1;
          minus_active_next = 1'b1;
          erase_req_next    = 1'b0;
          done_pending_next = 1'b0;
          if (one_sel) begin
            state_next = PLAY;
          end
        end

        PLAY: begin
          // The plus box has priority when both boxes share a cell.
          if (moveValid && plus_hit) begin
            bonus_score       = plus_score;
            plus_active_next  = 1'b0;
            erase_x_next      = scorePlusFiveX;
            erase_y_next      = scorePlusFiveY;
            erase_req_next    = 1'b1;
            done_pending_next = levelDone;
            state_next        = ERASE;
          end else if (moveValid && minus_hit) begin
            bonus_score       = minus_score;
            minus_active_next = 1'b0;
            erase_x_next      = scoreMinusFiveX;
            erase_y_next      = scoreMinusFiveY;
            erase_req_next    = 1'b1;
            done_pending_next = levelDone;
            state_next        = ERASE;
          end else if (levelDone) begin
            state_next = DONE;
          end
          // Time penalty is taken after any bonus of the same cycle.
          score_next = scoreTick ? dec_sat(bonus_score) : bonus_score;
        end

        ERASE: begin
          if (scoreTick) begin
            score_next = dec_sat(score_reg);
          end
          if (eraseAck) begin
            erase_req_next    = 1'b0;
            done_pending_next = 1'b0;
            state_next        = (done_pending_reg || levelDone) ? DONE : PLAY;
          end else if (levelDone) begin
            done_pending_next = 1'b1;
          end
        end

        DONE: begin
          // Frozen until externalReset or reset.
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      score_reg        <= START_S;
      plus_active_reg  <= 1'b1;
      minus_active_reg <= 1'b1;
      erase_req_reg    <= 1'b0;
      erase_x_reg      <= '0;
      erase_y_reg      <= '0;
      done_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      score_reg        <= score_next;
      plus_active_reg  <= plus_active_next;
      minus_active_reg <= minus_active_next;
      erase_req_reg    <= erase_req_next;
      erase_x_reg      <= erase_x_next;
      erase_y_reg      <= erase_y_next;
      done_pending_reg <= done_pending_next;
    end
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_active_reg <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      level_active_reg <= (state_next == PLAY) || (state_next == ERASE);
      game_over_reg    <= (state_next == DONE);
    end
  end

  assign score          = score_reg;
  assign plusBoxActive  = plus_active_reg;
  assign minusBoxActive = minus_active_reg;
  assign eraseReq       = erase_req_reg;
  assign eraseX         = erase_x_reg;
  assign eraseY         = erase_y_reg;
  assign levelActive    = level_active_reg;
  assign gameOver       = game_over_reg;

endmodule
